mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter that shares one 8-to-1 multiplexer between eight requesters. Each requester raises its `req` bit to claim the shared mux. The arbiter grants one owner at a time, drives the mux select with that owner's index, and limits each ownership to at most `MAX_HOLD` cycles so no requester is starved. It sits directly in front of the 8-to-1 mux `sel` input; `grant` goes back to the requesters.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive cycles one owner keeps the grant. Legal range 1..255.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `req` input 8: request vector. Bit i is requester i.
- `grant` output 8: one-hot grant, or all zero when idle. Registered.
- `sel` output 3: index of the current owner, wired to the mux select. Registered.
- `sel_valid` output 1: high while an owner holds the mux. Registered.

## Operation
- Two states:
  - IDLE: `grant=0`, `sel_valid=0`.
  - OWN: exactly one `grant` bit is set, `sel_valid=1`, and `sel` equals the index of that bit.
- Round-robin pointer `ptr` (3 bits): the search starts at `ptr` and proceeds ptr, ptr+1, …, 7, 0, … (wrapping mod 8). The first set `req` bit found wins.
- IDLE -> OWN:
  - Condition: any `req` bit is set.
  - Actions: load the winner into the owner register and set the hold counter `cnt=1`.
- In OWN, the owner is released when either condition holds:
  - `req[owner]==0`, or
  - `cnt==MAX_HOLD`.
- On release:
  - Set `ptr = owner+1` (mod 8).
  - Re-arbitrate in the same cycle, with the search starting at owner+1. The releasing owner therefore has the lowest priority but may win again if it is the only requester.
  - If a winner exists: stay in OWN with the new owner, `cnt=1`.
  - Otherwise go to IDLE.
- In OWN with no release: `cnt` increments and the owner is unchanged.
- `sel` keeps its last value in IDLE. Downstream logic must qualify `sel` with `sel_valid`.
- The counter width is sized to hold `MAX_HOLD` and never wraps.
- `ptr` does not change when a grant starts from IDLE; it updates only on release.

## Timing
- Reset values: `grant=8'b0`, `sel=3'd0`, `sel_valid=0`, `ptr=0`, `cnt=0`, state IDLE. Reset wins over any simultaneous `req`.
- Reset asserted during OWN: outputs return to their reset values on the next edge, with no completion of the current hold.
- Grant latency from IDLE: `req` sampled high at edge k gives `grant`/`sel`/`sel_valid` valid after edge k.
- Handover: the old owner drops `req` before edge k. After edge k the new owner is granted. No idle bubble occurs when another request is pending.
- Hold limit: an owner that keeps `req` high sees `grant` for exactly `MAX_HOLD` consecutive cycles. It may then regain the grant immediately only if no other bit of `req` is set.
- `req` deasserted by a non-owner has no effect. A `req` raised mid-hold waits its turn.
- All eight `req` bits set continuously with `MAX_HOLD=M`: grant order is 0,1,…,7,0,… and each grant lasts M cycles.

## Test plan
- Reset: hold `rst=1` with `req=8'hFF` -> `grant=0`, `sel=0`, `sel_valid=0`. Release `rst` -> next edge `grant=8'h01`, `sel=0`.
- Single requester: `req=8'h20` held with `MAX_HOLD=4` -> `grant=8'h20`, `sel=5` continuously, and `cnt` restarts every 4 cycles. Drop `req` -> IDLE one edge later.
- Fairness: `req=8'hFF` held -> `sel` sequence 0,1,…,7,0, each for 4 cycles. No index is skipped or repeated out of order.
- Early release and wrap: owner 7 drops `req` while `req=8'h05` -> next owner is 0, then 2. `ptr` wraps 7 -> 0.
- Late arrival: owner 3 holding, `req[1]` rises at cycle 1 of the hold -> owner 3 keeps the grant for the full `MAX_HOLD`, then `sel=1` with no `sel_valid` gap.
- Mid-operation reset: `rst` pulsed during OWN at `sel=4` -> outputs cleared at the next edge. With `req=8'h1F`, the first grant after reset goes to index 0 (`ptr` reset).

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner arbiter for a shared 8-to-1 mux: one-hot grant, registered select,
// and a per-owner hold limit so a busy requester cannot starve the others.
module mux_rr_arbiter #(
   parameter int MAX_HOLD = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_req,
   output logic [7:0] o_grant,
   output logic [2:0] o_sel,
   output logic       o_sel_valid
);

   localparam int CNT_W = $clog2(MAX_HOLD + 1);
   localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   state_t           r_state;
   logic [2:0]       r_owner;
   logic [2:0]       r_ptr;
   logic [CNT_W-1:0] r_cnt;
   logic [7:0]       r_grant;
   logic [2:0]       r_sel;
   logic             r_sel_valid;

   logic [2:0]       w_owner_next;
   logic             w_release;
   logic [2:0]       w_start;
   logic [3:0]       w_pick;
   logic             w_found;
   logic [2:0]       w_idx;

   // Returns {found, index} of the first set request at or after start, wrapping mod 8.
   // Scanning from the farthest offset down lets the nearest hit overwrite earlier ones.
   function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] start);
      logic [3:0] res;
      logic [2:0] idx;
      res = 4'd0;
      for (int i = 7; i >= 0; i--) begin
         idx = start + 3'(i);
         if (req[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   assign w_owner_next = r_owner + 3'd1;
   assign w_release    = (r_state == OWN) && (!i_req[r_owner] || (r_cnt == HOLD_LIMIT));
   assign w_start      = (r_state == OWN) ? w_owner_next : r_ptr;
   assign w_pick       = rr_pick(i_req, w_start);
   assign w_found      = w_pick[3];
   assign w_idx        = w_pick[2:0];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_owner     <= 3'd0;
         r_ptr       <= 3'd0;
         r_cnt       <= '0;
         r_grant     <= 8'd0;
         r_sel       <= 3'd0;
         r_sel_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_state     <= OWN;
                  r_owner     <= w_idx;
                  r_cnt       <= CNT_W'(1);
                  r_grant     <= 8'd1 << w_idx;
                  r_sel       <= w_idx;
                  r_sel_valid <= 1'b1;
               end
            end
            OWN: begin
               if (w_release) begin
                  // Releasing owner drops to lowest priority, but may win again if alone.
                  r_ptr <= w_owner_next;
                  if (w_found) begin
                     r_owner     <= w_idx;
                     r_cnt       <= CNT_W'(1);
                     r_grant     <= 8'd1 << w_idx;
                     r_sel       <= w_idx;
                     r_sel_valid <= 1'b1;
                  end else begin
                     r_state     <= IDLE;
                     r_cnt       <= '0;
                     r_grant     <= 8'd0;
                     r_sel_valid <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_grant     = r_grant;
   assign o_sel       = r_sel;
   assign o_sel_valid = r_sel_valid;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: directed request vectors with hand-computed
// grant/sel/valid expectations, checked by an independent monitor after each edge.
module tb_mux_rr_arbiter;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic [7:0] grant;
   logic [2:0] sel;
   logic       sel_valid;

   typedef struct {
      int         tag;
      logic [7:0] g;
      logic [2:0] s;
      logic       v;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   vec_no = 0;

   mux_rr_arbiter #(.MAX_HOLD(4)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req       (req),
      .o_grant     (grant),
      .o_sel       (sel),
      .o_sel_valid (sel_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs and queue the outputs expected after the next edge.
   task automatic apply(input logic r, input logic [7:0] rq,
                        input logic [7:0] g, input logic [2:0] s, input logic v);
      exp_t e;
      @(negedge clk);
      rst = r;
      req = rq;
      e.tag = vec_no;
      e.g = g;
      e.s = s;
      e.v = v;
      exp_q.push_back(e);
      vec_no++;
   endtask

   // Monitor: compare the DUT outputs against the oldest queued expectation.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (grant !== e.g || sel !== e.s || sel_valid !== e.v) begin
            errors++;
            $display("FAIL vec%0d grant=%h sel=%0d valid=%b required grant=%h sel=%0d valid=%b",
                     e.tag, grant, sel, sel_valid, e.g, e.s, e.v);
         end
      end
   end

   initial begin
      int k;
      rst = 1'b1;
      req = 8'h00;

      // Reset wins over requests
      apply(1, 8'hFF, 8'h00, 3'd0, 0);
      apply(1, 8'hFF, 8'h00, 3'd0, 0);

      // Fairness: all requesting, owners 0..7 then 0, four cycles each
      for (int o = 0; o < 9; o++)
         for (int c = 0; c < 4; c++) begin
            k = o % 8;
            apply(0, 8'hFF, 8'd1 << k, 3'(k), 1);
         end

      // Single requester 5 regains the grant back to back after each hold limit
      for (int c = 0; c < 8; c++) apply(0, 8'h20, 8'h20, 3'd5, 1);
      apply(0, 8'h00, 8'h00, 3'd5, 0);
      apply(0, 8'h00, 8'h00, 3'd5, 0);

      // Early release of owner 7 wraps the pointer to 0, then 2
      apply(0, 8'h80, 8'h80, 3'd7, 1);
      apply(0, 8'h85, 8'h80, 3'd7, 1);
      apply(0, 8'h05, 8'h01, 3'd0, 1);
      apply(0, 8'h05, 8'h01, 3'd0, 1);
      apply(0, 8'h04, 8'h04, 3'd2, 1);
      apply(0, 8'h00, 8'h00, 3'd2, 0);

      // Late arrival: owner 3 keeps its full hold, then 1 with no valid gap
      apply(0, 8'h08, 8'h08, 3'd3, 1);
      apply(0, 8'h0A, 8'h08, 3'd3, 1);
      apply(0, 8'h0A, 8'h08, 3'd3, 1);
      apply(0, 8'h0A, 8'h08, 3'd3, 1);
      apply(0, 8'h0A, 8'h02, 3'd1, 1);
      apply(0, 8'h02, 8'h02, 3'd1, 1);
      apply(0, 8'h00, 8'h00, 3'd1, 0);

      // Mid-hold reset at owner 4; pointer restarts from 0
      apply(0, 8'h10, 8'h10, 3'd4, 1);
      apply(0, 8'h1F, 8'h10, 3'd4, 1);
      apply(1, 8'h1F, 8'h00, 3'd0, 0);
      apply(0, 8'h1F, 8'h01, 3'd0, 1);

      // Non-owners dropping requests leave the owner untouched
      apply(0, 8'h01, 8'h01, 3'd0, 1);
      apply(0, 8'h01, 8'h01, 3'd0, 1);
      apply(0, 8'h01, 8'h01, 3'd0, 1);
      apply(0, 8'h01, 8'h01, 3'd0, 1);
      apply(0, 8'h00, 8'h00, 3'd0, 0);

      // Drain the scoreboard with a bounded wait
      for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
